// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: directed-test sequencer for a single-bit combinational gate.
// Latches N_VEC stimulus/expected bits at start, drives each stimulus bit,
// waits SETTLE cycles, samples the gate output and tallies mismatches.
// Optional feature macro: SEQ_CTRL_STOP_ON_FAIL_EN (when defined, the run
// ends at the first mismatching vector instead of running all N_VEC).
module gate_seq_ctrl #(
  parameter int N_VEC  = 8,
  parameter int SETTLE = 2,
  parameter int IDX_W  = $clog2(N_VEC + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [N_VEC-1:0] pattern_i,
  input  logic [N_VEC-1:0] expect_i,
  output logic             in_o,
  input  logic             out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [IDX_W-1:0] err_cnt_o,
  output logic [IDX_W-1:0] fail_idx_o
);

  // The settle counter counts SETTLE-1 down to 0; keep it at least 1 bit wide.
  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_VEC - 1);
  localparam logic [IDX_W-1:0] IDX_NONE  = IDX_W'(N_VEC);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic [N_VEC-1:0]  pat_q;
  logic [N_VEC-1:0]  exp_q;

  logic              mismatch;
  logic              stop_run;
  logic [IDX_W-1:0]  err_nxt;
  logic [IDX_W-1:0]  nxt_idx;

  // Select bit i of a vector through a shift so any index width is accepted.
  function automatic logic bit_at(input logic [N_VEC-1:0] v, input logic [IDX_W-1:0] i);
    logic [N_VEC-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  assign mismatch = (out_i != bit_at(exp_q, idx));
  assign err_nxt  = err_cnt_o + IDX_W'(mismatch);
  assign nxt_idx  = idx + IDX_ONE;

`ifdef SEQ_CTRL_STOP_ON_FAIL_EN
  assign stop_run = (idx == IDX_LAST) || mismatch;
`else
  assign stop_run = (idx == IDX_LAST);
`endif

  // Vector storage: captured only when a start is accepted, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && start_i && !abort_i) begin
      pat_q <= pattern_i;
      exp_q <= expect_i;
    end
  end

  // Sequencer FSM with registered outputs; abort preempts every non-idle state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      idx        <= '0;
      wait_cnt   <= '0;
      in_o       <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      err_cnt_o  <= '0;
      fail_idx_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (abort_i && state != S_IDLE) begin
        state  <= S_IDLE;
        in_o   <= 1'b0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !abort_i) begin
              idx        <= '0;
              err_cnt_o  <= '0;
              fail_idx_o <= IDX_NONE;
              pass_o     <= 1'b0;
              in_o       <= pattern_i[0];
              busy_o     <= 1'b1;
              state      <= S_DRIVE;
            end
          end
          S_DRIVE: begin
            if (SETTLE > 0) begin
              wait_cnt <= WAIT_LOAD;
              state    <= S_WAIT;
            end else begin
              state <= S_SAMPLE;
            end
          end
          S_WAIT: begin
            if (wait_cnt == '0) begin
              state <= S_SAMPLE;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          S_SAMPLE: begin
            err_cnt_o <= err_nxt;
            if (mismatch && fail_idx_o == IDX_NONE) begin
              fail_idx_o <= idx;
            end
            if (stop_run) begin
              state  <= S_DONE;
              in_o   <= 1'b0;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= (err_nxt == '0);
            end else begin
              idx   <= nxt_idx;
              in_o  <= bit_at(pat_q, nxt_idx);
              state <= S_DRIVE;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state  <= S_IDLE;
            in_o   <= 1'b0;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/gate_seq_ctrl.md
# gate_seq_ctrl

Directed-test sequencer for a single-bit combinational gate under test (one input, one output). It latches a vector of stimulus bits and expected results, drives the gate input one bit at a time, waits a programmable settle time, samples the gate output, and compares it against the expected value. It reports pass/fail, a mismatch count, and the index of the first failure. It sits between the bench (or a higher-level test controller) and the gate datapath, and replaces hand-written per-cycle stimulus.

## Interface
Parameters:
- N_VEC, 8, number of vectors per run (≥1)
- SETTLE, 2, wait cycles between drive and sample (≥0)
- IDX_W, $clog2(N_VEC+1), width of the count and index outputs

Ports:
- clk_i  in  1  the single clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin a run; sampled only in IDLE
- abort_i  in  1  terminate the run; highest priority after reset
- pattern_i  in  N_VEC  stimulus bits; vector i uses bit i (LSB first); latched at start
- expect_i  in  N_VEC  expected output bits; latched at start
- in_o  out  1  drives the gate input
- out_i  in  1  gate output, sampled in SAMPLE
- busy_o  out  1  high while a run is in progress (DRIVE/WAIT/SAMPLE)
- done_o  out  1  one-cycle pulse when a run completes
- pass_o  out  1  high when the last completed run had zero mismatches
- err_cnt_o  out  IDX_W  mismatch count
- fail_idx_o  out  IDX_W  index of the first mismatch; N_VEC if there were none

## Operation
- States: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE:
  - start_i=1 latches pattern_i and expect_i, clears idx, sets err_cnt_o=0, fail_idx_o=N_VEC, pass_o=0, then moves to DRIVE.
- DRIVE: in_o=pattern[idx]. Moves to WAIT if SETTLE>0, otherwise to SAMPLE.
- WAIT: holds in_o for exactly SETTLE cycles, then moves to SAMPLE.
- SAMPLE: compares out_i with expect[idx] at the closing edge.
  - On a mismatch, err_cnt_o increments, and fail_idx_o=idx if it still equals N_VEC.
  - If idx=N_VEC-1, the next state is DONE; otherwise idx increments and the next state is DRIVE.
- DONE: done_o=1 for one cycle. pass_o=(err_cnt_o==0) is set on entry. Returns to IDLE.
- in_o is 0 in IDLE and DONE.
- Results hold until the next accepted start.
- start_i outside IDLE (including in DONE) is ignored; it is not queued.
- abort_i=1 in any non-IDLE state:
  - next state IDLE, in_o→0, busy_o→0, no done_o pulse
  - pass_o stays 0; err_cnt_o and fail_idx_o keep their partial values
- abort_i and start_i high together in IDLE: abort wins, start is ignored.
- err_cnt_o saturation is impossible: maximum value N_VEC fits in IDX_W.

## Timing
- Reset values: in_o=0, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, fail_idx_o=0. State is IDLE. All are asynchronous, including reset asserted mid-run.
- start_i is sampled at edge E0. At E0 busy_o rises and in_o=pattern[0].
- Each vector takes SETTLE+2 cycles.
- done_o rises at E0+N_VEC·(SETTLE+2) and falls one cycle later.
- busy_o falls at the same edge done_o rises.
- Results are valid when done_o is high.
- The earliest next start is in the cycle after done_o.
- Defaults: 32 cycles per run.

## Configuration
- SEQ_CTRL_STOP_ON_FAIL_EN:
  - Defined: a mismatch in SAMPLE sends the FSM straight to DONE.
    - done_o pulses, pass_o=0, err_cnt_o=1, fail_idx_o=failing index.
    - Latency is (k+1)·(SETTLE+2) for a failure at index k.
  - Undefined: all N_VEC vectors always run.

## Test plan
- Inverter DUT (out_i=~in_o), pattern_i=8'hA6, expect_i=8'h59, start → done_o at E0+32, pass_o=1, err_cnt_o=0, fail_idx_o=8.
- Inverter DUT, expect_i=pattern_i=8'hA6 → err_cnt_o=8, fail_idx_o=0, pass_o=0.
- Inverter DUT, expect_i=8'h79 (bit 5 wrong):
  - macro off: err_cnt_o=1, fail_idx_o=5, done_o at E0+32
  - macro on: done_o at E0+24, err_cnt_o=1
- start_i pulsed at E0+5 → ignored, done_o still at E0+32. abort_i at E0+10 in a second run → busy_o=0 next edge, no done_o, pass_o=0.
- rst_i asserted at E0+13 → all outputs reset immediately without a clock edge. A start after release completes normally with correct results.
- SETTLE=0 build, inverter DUT, expect_i=~pattern_i → done_o at E0+16, pass_o=1.
